mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the instruction-fetch requester (PC/fetch stage) and the data requester (load/store path driven by mem_write/result_src).
- Sequences one outstanding transaction at a time through a small FSM.
- Data requests take priority over fetch.
- A watchdog aborts a transaction that is never acknowledged.

Parameters:
ADDR_WIDTH, 16, byte address width (matches pc width)
DATA_WIDTH, 32, memory data width
TIMEOUT, 255, max cycles in a busy state before abort (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-low
if_req  input  1  fetch request; held high with stable if_addr until if_valid
if_addr  input  ADDR_WIDTH  fetch address
if_valid  output  1  one-cycle pulse: fetch complete, if_rdata valid
if_rdata  output  DATA_WIDTH  fetched instruction
dm_req  input  1  data request; held high, operands stable, until dm_valid
dm_we  input  1  1 = store, 0 = load
dm_addr  input  ADDR_WIDTH  data address
dm_wdata  input  DATA_WIDTH  store data
dm_valid  output  1  one-cycle pulse: data access complete
dm_rdata  output  DATA_WIDTH  load data (0 for stores)
mem_req  output  1  memory request, held until mem_ack or abort
mem_we  output  1  memory write enable
mem_addr  output  ADDR_WIDTH  memory address
mem_wdata  output  DATA_WIDTH  memory write data
mem_rdata  input  DATA_WIDTH  memory read data, valid when mem_ack=1
mem_ack  input  1  memory completion, single cycle
err  output  1  one-cycle pulse alongside the valid of an aborted transaction
busy  output  1  1 in any state except IDLE

Behaviour:
- States: IDLE, IF_BUSY, DM_BUSY, RESP. All outputs are registered.
- Reset (rst=0 at a clock edge), from any state including mid-transaction:
  - State goes to IDLE.
  - mem_req, mem_we, if_valid, dm_valid, err and busy go to 0.
  - mem_addr, mem_wdata, if_rdata and dm_rdata go to 0.
  - Watchdog counter goes to 0.
  - A pending mem_ack is ignored.
- IDLE grant rules:
  - dm_req=1: go to DM_BUSY. Latch mem_we=dm_we, mem_addr=dm_addr, mem_wdata=dm_wdata (0 if load). Set mem_req=1 at the next edge. Data wins when both requests are high.
  - Only if_req=1: go to IF_BUSY. Set mem_we=0, mem_addr=if_addr, mem_req=1.
  - Grant latency: request seen in cycle N gives mem_req=1 in cycle N+1.
- IF_BUSY / DM_BUSY:
  - mem_req stays 1 and mem_addr/mem_we/mem_wdata stay stable.
  - Requester inputs are not re-sampled.
  - The counter increments each cycle.
  - mem_ack=1 in cycle M:
    - mem_req=0 at M+1.
    - The owner's valid=1 at M+1.
    - rdata is captured from mem_rdata: fetch always; data only when mem_we=0, else 0.
    - State goes to RESP.
  - Counter reaches TIMEOUT with no ack:
    - mem_req drops.
    - Owner's valid=1 together with err=1; rdata=0.
    - State goes to RESP.
  - If ack and timeout coincide, the ack wins and err=0.
- RESP:
  - Lasts exactly one cycle; valid and err pulses last exactly this cycle.
  - Requests are ignored here, so a requester still holding req during its valid cycle is not re-granted.
  - The counter clears and the state returns to IDLE.
  - A new grant is possible the cycle after RESP, so the minimum back-to-back period is 3 cycles with a zero-wait memory.
- mem_ack outside the busy states is ignored, with no output change.
- Fetch starvation is bounded by the data requester: the core issues at most one data access per instruction.
- Counter width is $clog2(TIMEOUT+1). The counter saturates, never wraps.

Test Plan:
- Reset: hold rst=0 for 2 cycles with if_req=1 -> all outputs 0, busy=0; release rst -> mem_req=1, mem_addr=if_addr one cycle later.
- Fetch: if_req=1, if_addr=0x0004; mem_ack after 2 wait cycles with mem_rdata=0x00500093 -> if_valid pulse 1 cycle after ack, if_rdata=0x00500093, err=0, dm_valid=0.
- Collision: if_req and dm_req both rise together, dm_we=1, dm_addr=0x0100, dm_wdata=0xDEADBEEF -> store granted first with mem_we=1 and matching address/data; after dm_valid, fetch is granted, never before.
- Load data: dm_we=0, ack with mem_rdata=0x12345678 -> dm_rdata=0x12345678. Store case -> dm_rdata=0.
- Timeout: TIMEOUT=4, no mem_ack -> mem_req drops after 4 busy cycles; dm_valid=1 and err=1 for one cycle, dm_rdata=0. Ack on the same cycle the counter hits 4 -> err=0.
- Robustness: stray mem_ack in IDLE -> no valid pulse. rst=0 while in DM_BUSY -> IDLE next cycle, no dm_valid pulse.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_port_arbiter_if : fetch/data requester and unified memory port bundle
// Revision: 1.0
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_valid;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic                  dm_valid;
  logic [DATA_WIDTH-1:0] dm_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  logic                  err;
  logic                  busy;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_valid, if_rdata, dm_valid, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, err, busy
  );

  // Requesters and memory side
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_valid, if_rdata, dm_valid, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, err, busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_port_arbiter : one-at-a-time fetch/data arbiter for a unified memory port
// Revision: 1.0
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);
  localparam int                 CNT_W       = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   C_CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   C_CNT_MAX   = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t                r_state,     w_state_nxt;
  logic [CNT_W-1:0]      r_cnt,       w_cnt_nxt;
  logic                  r_mem_req,   w_mem_req_nxt;
  logic                  r_mem_we,    w_mem_we_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr,  w_mem_addr_nxt;
  logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic                  r_if_valid,  w_if_valid_nxt;
  logic [DATA_WIDTH-1:0] r_if_rdata,  w_if_rdata_nxt;
  logic                  r_dm_valid,  w_dm_valid_nxt;
  logic [DATA_WIDTH-1:0] r_dm_rdata,  w_dm_rdata_nxt;
  logic                  r_err,       w_err_nxt;
  logic                  r_busy,      w_busy_nxt;
  logic                  w_owner_dm;

  assign w_owner_dm = (r_state == DM_BUSY);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_if_valid_nxt  = 1'b0;
    w_if_rdata_nxt  = r_if_rdata;
    w_dm_valid_nxt  = 1'b0;
    w_dm_rdata_nxt  = r_dm_rdata;
    w_err_nxt       = 1'b0;

    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        // Data path has priority over fetch when both ask in the same cycle
        if (bus.dm_req) begin
          w_state_nxt     = DM_BUSY;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = bus.dm_we;
          w_mem_addr_nxt  = bus.dm_addr;
          w_mem_wdata_nxt = bus.dm_we ? bus.dm_wdata : '0;
        end else if (bus.if_req) begin
          w_state_nxt     = IF_BUSY;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = 1'b0;
          w_mem_addr_nxt  = bus.if_addr;
          w_mem_wdata_nxt = '0;
        end
      end
      IF_BUSY, DM_BUSY: begin
        w_cnt_nxt = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
        // An ack in the final watchdog cycle still completes normally
        if (bus.mem_ack) begin
          w_state_nxt   = RESP;
          w_mem_req_nxt = 1'b0;
          if (w_owner_dm) begin
            w_dm_valid_nxt = 1'b1;
            w_dm_rdata_nxt = r_mem_we ? '0 : bus.mem_rdata;
          end else begin
            w_if_valid_nxt = 1'b1;
            w_if_rdata_nxt = bus.mem_rdata;
          end
        end else if (r_cnt >= C_CNT_LAST) begin
          w_state_nxt   = RESP;
          w_mem_req_nxt = 1'b0;
          w_err_nxt     = 1'b1;
          if (w_owner_dm) begin
            w_dm_valid_nxt = 1'b1;
            w_dm_rdata_nxt = '0;
          end else begin
            w_if_valid_nxt = 1'b1;
            w_if_rdata_nxt = '0;
          end
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_valid  <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_valid  <= 1'b0;
      r_dm_rdata  <= '0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_if_valid  <= w_if_valid_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_dm_valid  <= w_dm_valid_nxt;
      r_dm_rdata  <= w_dm_rdata_nxt;
      r_err       <= w_err_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_valid  = r_if_valid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_valid  = r_dm_valid;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.err       = r_err;
  assign bus.busy      = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter : scenario tasks plus a randomized transaction-level check
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [DW-1:0] last_if_rd;
  logic [DW-1:0] last_dm_rd;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  // Counts falling edges until mem_req is seen (bounded)
  task automatic wait_grant(output int lat);
    lat = 0;
    while (bus.mem_req !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Memory model: acks in busy cycle waitc+1, returns number of busy cycles seen
  task automatic serve(input int waitc, input logic [DW-1:0] rd, output int nbusy);
    nbusy = 0;
    while (bus.mem_req === 1'b1 && nbusy < 20) begin
      nbusy++;
      bus.mem_ack   = (nbusy == waitc + 1);
      bus.mem_rdata = bus.mem_ack ? rd : DW'($urandom);
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    int lat, nb;
    rst = 1'b0;
    idle_inputs();
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0040;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.if_valid, bus.dm_valid, bus.err, bus.busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {bus.mem_req, bus.mem_we, bus.if_valid, bus.dm_valid, bus.err, bus.busy});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.dm_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h want all 0",
               bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.dm_rdata);
    end
    rst = 1'b1;
    wait_grant(lat);
    checks++;
    if (lat != 1 || bus.mem_addr !== 16'h0040) begin
      errors++;
      $display("FAIL reset_release_grant: got lat=%0d addr=%h want lat=1 addr=0040", lat, bus.mem_addr);
    end
    serve(0, 32'h0, nb);
    bus.if_req = 1'b0;
    @(negedge clk);
    last_if_rd = 32'h0;
    last_dm_rd = 32'h0;
  endtask

  task automatic test_fetch();
    int lat, nb;
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0004;
    wait_grant(lat);
    checks++;
    if (lat != 1 || bus.mem_addr !== 16'h0004 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL fetch_grant: got lat=%0d addr=%h we=%b want 1 0004 0", lat, bus.mem_addr, bus.mem_we);
    end
    serve(2, 32'h00500093, nb);
    checks++;
    if (nb != 3) begin
      errors++;
      $display("FAIL fetch_busy_cycles: got %0d want 3", nb);
    end
    checks++;
    if ({bus.if_valid, bus.dm_valid, bus.err, bus.mem_req} !== 4'b1000 || bus.if_rdata !== 32'h00500093) begin
      errors++;
      $display("FAIL fetch_resp: got v/dv/err/req=%b rdata=%h want 1000 00500093",
               {bus.if_valid, bus.dm_valid, bus.err, bus.mem_req}, bus.if_rdata);
    end
    bus.if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.if_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL fetch_pulse_width: got valid=%b busy=%b want 0 0", bus.if_valid, bus.busy);
    end
    last_if_rd = 32'h00500093;
  endtask

  task automatic test_collision();
    int lat, nb;
    bus.if_req   = 1'b1;
    bus.if_addr  = 16'h0008;
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 16'h0100;
    bus.dm_wdata = 32'hDEADBEEF;
    wait_grant(lat);
    checks++;
    if (lat != 1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0100 || bus.mem_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL collision_store_first: got lat=%0d we=%b addr=%h wdata=%h want 1 1 0100 deadbeef",
               lat, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    serve(1, 32'hAAAA5555, nb);
    checks++;
    if ({bus.dm_valid, bus.if_valid, bus.err} !== 3'b100 || bus.dm_rdata !== 32'h0) begin
      errors++;
      $display("FAIL collision_store_resp: got dv/iv/err=%b rdata=%h want 100 00000000",
               {bus.dm_valid, bus.if_valid, bus.err}, bus.dm_rdata);
    end
    bus.dm_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL collision_no_early_fetch: got req=%b busy=%b want 0 0", bus.mem_req, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0008) begin
      errors++;
      $display("FAIL collision_fetch_grant: got req=%b we=%b addr=%h want 1 0 0008",
               bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    serve(0, 32'h00000013, nb);
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'h00000013) begin
      errors++;
      $display("FAIL collision_fetch_resp: got valid=%b rdata=%h want 1 00000013", bus.if_valid, bus.if_rdata);
    end
    bus.if_req = 1'b0;
    @(negedge clk);
    last_if_rd = 32'h00000013;
    last_dm_rd = 32'h0;
  endtask

  task automatic test_load_store();
    int lat, nb;
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = 16'h0200;
    bus.dm_wdata = 32'hFFFFFFFF;
    wait_grant(lat);
    checks++;
    if (lat != 1 || bus.mem_we !== 1'b0 || bus.mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL load_grant: got lat=%0d we=%b wdata=%h want 1 0 00000000", lat, bus.mem_we, bus.mem_wdata);
    end
    serve(1, 32'h12345678, nb);
    checks++;
    if (bus.dm_valid !== 1'b1 || bus.dm_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL load_data: got valid=%b rdata=%h want 1 12345678", bus.dm_valid, bus.dm_rdata);
    end
    bus.dm_req = 1'b0;
    @(negedge clk);
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_wdata = 32'h01020304;
    wait_grant(lat);
    serve(0, 32'hCAFEF00D, nb);
    checks++;
    if (bus.dm_valid !== 1'b1 || bus.dm_rdata !== 32'h0) begin
      errors++;
      $display("FAIL store_rdata_zero: got valid=%b rdata=%h want 1 00000000", bus.dm_valid, bus.dm_rdata);
    end
    bus.dm_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int lat, nb;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 16'h0300;
    wait_grant(lat);
    serve(100, 32'h55555555, nb);
    checks++;
    if (nb != TO) begin
      errors++;
      $display("FAIL timeout_busy_cycles: got %0d want %0d", nb, TO);
    end
    checks++;
    if ({bus.dm_valid, bus.err, bus.mem_req} !== 3'b110 || bus.dm_rdata !== 32'h0) begin
      errors++;
      $display("FAIL timeout_resp: got dv/err/req=%b rdata=%h want 110 00000000",
               {bus.dm_valid, bus.err, bus.mem_req}, bus.dm_rdata);
    end
    bus.dm_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b0 || bus.dm_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err_pulse: got err=%b valid=%b want 0 0", bus.err, bus.dm_valid);
    end
    bus.dm_req = 1'b1;
    wait_grant(lat);
    serve(TO - 1, 32'h77777777, nb);
    checks++;
    if (nb != TO || {bus.dm_valid, bus.err} !== 2'b10 || bus.dm_rdata !== 32'h77777777) begin
      errors++;
      $display("FAIL timeout_ack_wins: got nb=%0d dv/err=%b rdata=%h want %0d 10 77777777",
               nb, {bus.dm_valid, bus.err}, bus.dm_rdata, TO);
    end
    bus.dm_req = 1'b0;
    @(negedge clk);
    last_dm_rd = 32'h77777777;
  endtask

  task automatic test_robust();
    int lat;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hBADC0FFE;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({bus.if_valid, bus.dm_valid, bus.busy, bus.mem_req} !== 4'b0 ||
          bus.if_rdata !== last_if_rd || bus.dm_rdata !== last_dm_rd) begin
        errors++;
        $display("FAIL stray_ack: got flags=%b ird=%h drd=%h want 0000 %h %h",
                 {bus.if_valid, bus.dm_valid, bus.busy, bus.mem_req}, bus.if_rdata, bus.dm_rdata,
                 last_if_rd, last_dm_rd);
      end
    end
    bus.mem_ack  = 1'b0;
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 16'h0400;
    bus.dm_wdata = 32'h11112222;
    wait_grant(lat);
    rst         = 1'b0;
    bus.mem_ack = 1'b1;
    bus.dm_req  = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.mem_req, bus.dm_valid, bus.err} !== 4'b0 || bus.dm_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_txn: got busy/req/dv/err=%b rdata=%h want 0000 00000000",
               {bus.busy, bus.mem_req, bus.dm_valid, bus.err}, bus.dm_rdata);
    end
    rst         = 1'b1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.dm_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_txn_after: got busy=%b valid=%b want 0 0", bus.busy, bus.dm_valid);
    end
  endtask

  // Transaction-level model: grant order from priority, outcome from wait vs. TIMEOUT
  task automatic test_random();
    int lat, nb, kind, waitc, exp_nb, exp_lat;
    bit exp_err, is_dm;
    bit owners[$];
    logic [AW-1:0] ia, da;
    logic [DW-1:0] wd, rd, exp_rd, got_rd;
    logic we;
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(1, 3);
      ia   = AW'($urandom);
      da   = AW'($urandom);
      wd   = DW'($urandom);
      we   = 1'($urandom_range(0, 1));
      bus.if_req   = (kind != 2);
      bus.if_addr  = ia;
      bus.dm_req   = (kind != 1);
      bus.dm_we    = we;
      bus.dm_addr  = da;
      bus.dm_wdata = wd;
      owners.delete();
      if (kind != 1) owners.push_back(1'b1);
      if (kind != 2) owners.push_back(1'b0);
      exp_lat = 1;
      while (owners.size() > 0) begin
        is_dm = owners.pop_front();
        wait_grant(lat);
        checks++;
        if (lat != exp_lat || bus.mem_we !== (is_dm ? we : 1'b0) ||
            bus.mem_addr !== (is_dm ? da : ia) || bus.mem_wdata !== ((is_dm && we) ? wd : '0)) begin
          errors++;
          $display("FAIL rand_grant[%0d]: got lat=%0d we=%b addr=%h wdata=%h want %0d %b %h %h",
                   it, lat, bus.mem_we, bus.mem_addr, bus.mem_wdata, exp_lat,
                   is_dm ? we : 1'b0, is_dm ? da : ia, (is_dm && we) ? wd : '0);
        end
        waitc   = $urandom_range(0, 5);
        rd      = DW'($urandom);
        exp_err = (waitc >= TO);
        exp_nb  = exp_err ? TO : waitc + 1;
        exp_rd  = (exp_err || (is_dm && we)) ? '0 : rd;
        serve(waitc, rd, nb);
        got_rd = is_dm ? bus.dm_rdata : bus.if_rdata;
        checks++;
        if (nb != exp_nb || {bus.if_valid, bus.dm_valid, bus.err} !== {!is_dm, is_dm, exp_err} ||
            got_rd !== exp_rd) begin
          errors++;
          $display("FAIL rand_resp[%0d]: got nb=%0d iv/dv/err=%b rdata=%h want %0d %b %h",
                   it, nb, {bus.if_valid, bus.dm_valid, bus.err}, got_rd,
                   exp_nb, {!is_dm, is_dm, exp_err}, exp_rd);
        end
        if (is_dm) bus.dm_req = 1'b0;
        else       bus.if_req = 1'b0;
        exp_lat = 2;
      end
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin
        errors++;
        $display("FAIL rand_idle[%0d]: got busy=%b req=%b want 0 0", it, bus.busy, bus.mem_req);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_collision();
    test_load_store();
    test_timeout();
    test_robust();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "simulation time limit reached");
  end
endmodule
`default_nettype wire
